// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding and slice width.
package serial_adder_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int num_slices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/lookahead_adder_4bit.sv
// 4-bit carry-lookahead adder; all carries are flat two-level sums of products.
module lookahead_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Slice-serial add/subtract: one 4-bit slice per cycle through a shared CLA,
// LSB first, with carry held in a register between slices.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = num_slices(WIDTH);
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t state, state_nxt;

    logic [IDX_W-1:0]                idx;
    logic                            carry;
    logic [NSLICE-1:0][SLICE_W-1:0]  a_reg;
    logic [NSLICE-1:0][SLICE_W-1:0]  b_reg;
    logic [NSLICE-1:0][SLICE_W-1:0]  sum_reg;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               c_sl;
    logic               c_msb;

    assign a_sl = a_reg[idx];
    assign b_sl = b_reg[idx];

    lookahead_adder_4bit u_cla (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_sl)
    );

    // Carry into the slice MSB recovered from its sum bit; only used on the top slice.
    assign c_msb = a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ s_sl[SLICE_W-1];

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract as a + ~b + 1.
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{sub}};
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= s_sl;
                    carry        <= c_sl;
                    if (idx == LAST_IDX) begin
                        cout <= c_sl;
                        ovf  <= c_msb ^ c_sl;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum = sum_reg;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored); sampled with start.
REQ-006 SHALL have ports a, b  input  WIDTH each  operands; sampled with start.
REQ-007 SHALL have port cin  input  1  carry-in for add mode; sampled with start.
REQ-008 SHALL have port busy  output  1  high while slices are being computed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking sum/cout/ovf valid.
REQ-010 SHALL have port sum  output  WIDTH  result register.
REQ-011 SHALL have ports cout, ovf  output  1 each  unsigned carry-out; signed two's-complement overflow.

Function
REQ-012 SHALL compute the result one 4-bit slice per cycle, LSB slice first, through one shared 4-bit carry-lookahead adder.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE: on start=1, SHALL latch a, b XOR {WIDTH{sub}}, and carry register = sub ? 1 : cin; slice index := 0; go to RUN.
REQ-015 IDLE with start=0 SHALL hold state and all outputs.
REQ-016 RUN: each cycle SHALL add operand slice[index] and carry register, write the 4-bit result into sum slice[index], and store the adder carry-out into the carry register.
REQ-017 RUN: when index = WIDTH/4-1, SHALL go to DONE; otherwise index := index+1.
REQ-018 DONE: SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; never both.
REQ-020 Latency: start sampled on edge N SHALL yield done=1 in the cycle after edge N+WIDTH/4 (WIDTH=16: done is 5 cycles after the start cycle).
REQ-021 start in RUN or DONE SHALL be ignored; no queuing; input changes during RUN SHALL not affect the result.
REQ-022 sum SHALL hold its final value from DONE until the next accepted start; slices not yet written in a new operation retain prior values (sum is only defined at done).
REQ-023 cout SHALL equal final carry register; in sub mode cout=1 means no borrow (a >= b unsigned).
REQ-024 ovf SHALL equal carry into MSB XOR cout, registered at the final RUN cycle.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; wrap-around is reported only via cout/ovf.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force IDLE, index=0, carry register=0, sum=0, cout=0, ovf=0, busy=0, done=0.
REQ-027 Reset mid-RUN or in DONE SHALL abort with no done pulse; reset SHALL take priority over start in the same cycle.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the slice width constant 4.
REQ-029 SHALL instantiate exactly one existing lookahead_adder_4bit as the slice datapath; all sequencing in serial_adder_ctrl.

Verification
REQ-030 WIDTH=16, a=16'h00FF, b=16'h0001, sub=0, cin=0 -> done at cycle 5, sum=16'h0100, cout=0, ovf=0.
REQ-031 a=16'hFFFF, b=16'h0001, cin=1 -> sum=16'h0001, cout=1, ovf=0 (full-width carry ripple across all slices).
REQ-032 a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, cout=0, ovf=1; then a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0, ovf=0.
REQ-033 start held high continuously for 20 cycles with a=16'h1234, b=16'h1111 -> operations accepted only in IDLE, done every 6th cycle, sum=16'h2345 each time.
REQ-034 reset_n=0 asserted on the third RUN cycle -> next cycle busy=0, done=0, sum=0; no done pulse follows; a new start afterwards completes normally.
